// File: rtl/wavelet_pe_pkg.sv
// Shared constants, FSM state type, control bundle and level-length helper
// for the wavelet PE controller.
package wavelet_pe_pkg;
    localparam int MAX_FILTER_SIZE  = 16;
    localparam int OBUFF_CELL_COUNT = 2048;
    localparam int FS_WIDTH         = $clog2(MAX_FILTER_SIZE);
    localparam int OBUFF_ADDR_WIDTH = $clog2(OBUFF_CELL_COUNT);

    localparam logic [OBUFF_ADDR_WIDTH:0] OUT_LEN_MAX = (OBUFF_ADDR_WIDTH+1)'(OBUFF_CELL_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        SETUP = 3'd2,
        FEED  = 3'd3,
        FLUSH = 3'd4,
        DRAIN = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    typedef struct packed {
        logic pe_init;
        logic init_in_progress;
        logic fir_init;
        logic ibuff_base_rst;
        logic ibuff_offset_rst;
        logic ibuff_offset_cen;
        logic ibuff_offset_upcount;
        logic fir_hp_valid;
        logic fir_lp_valid;
        logic fir_flush;
        logic fir_disable_freezing;
        logic fir_force_freeze;
        logic obuff_offset_rst;
        logic obuff_hp_base_rst;
        logic obuff_lp_base_rst;
        logic obuff_hp_force_cen;
        logic busy;
        logic done;
        logic err;
    } ctrl_t;

    // One decomposition level yields (in_len + taps-1) / 2 outputs, clipped to the obuff depth.
    function automatic logic [OBUFF_ADDR_WIDTH-1:0] out_len(
        input logic [OBUFF_ADDR_WIDTH-1:0] in_len,
        input logic [FS_WIDTH-1:0]         fs
    );
        logic [OBUFF_ADDR_WIDTH:0] sum_v;
        logic [OBUFF_ADDR_WIDTH:0] half_v;
        sum_v  = {1'b0, in_len} + {{(OBUFF_ADDR_WIDTH+1-FS_WIDTH){1'b0}}, fs};
        half_v = sum_v >> 1;
        if (half_v > OUT_LEN_MAX) begin
            out_len = OUT_LEN_MAX[OBUFF_ADDR_WIDTH-1:0];
        end else begin
            out_len = half_v[OBUFF_ADDR_WIDTH-1:0];
        end
    endfunction
endpackage

// File: rtl/wavelet_pe_phase_counter.sv
// Loadable down-counter with zero flag; times the INIT, FEED and FLUSH phases.
module wavelet_pe_phase_counter
    import wavelet_pe_pkg::*;
#(
    parameter int WIDTH = OBUFF_ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] count_r;

    // Load wins over decrement; the count holds at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - WIDTH'(1);
        end
    end

    assign zero = (count_r == '0);
endmodule

// File: rtl/wavelet_pe_controller.sv
// Multi-level DWT sequencer: init, then per level setup/feed/flush/drain,
// driving every control input of wavelet_pe_datapath from registered outputs.
module wavelet_pe_controller
    import wavelet_pe_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  num_levels,
    input  logic [OBUFF_ADDR_WIDTH-1:0] signal_len,
    input  logic [FS_WIDTH-1:0]         filter_size,
    input  logic                        fir_lp_output_valid,
    output logic                        pe_init,
    output logic                        init_in_progress,
    output logic                        fir_init,
    output logic [1:0]                  cur_dec_level,
    output logic [OBUFF_ADDR_WIDTH-1:0] cur_outputs_len,
    output logic [OBUFF_ADDR_WIDTH-1:0] prev_outputs_len,
    output logic                        ibuff_r_addr_base_reg_rst,
    output logic                        ibuff_r_addr_offset_rst,
    output logic                        ibuff_r_addr_offset_cen,
    output logic                        ibuff_r_addr_offset_upcount,
    output logic                        fir_hp_input_valid,
    output logic                        fir_lp_input_valid,
    output logic                        fir_flush_pipeline,
    output logic                        fir_disable_freezing,
    output logic                        fir_force_freeze,
    output logic                        obuff_w_offset_rst,
    output logic                        obuff_w_hp_base_reg_rst,
    output logic                        obuff_w_lp_base_reg_rst,
    output logic                        obuff_w_hp_force_cen,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);
    localparam int AW  = OBUFF_ADDR_WIDTH;
    localparam int PAD = OBUFF_ADDR_WIDTH - FS_WIDTH;

    state_t               state_r, state_nx_s;
    ctrl_t                ctrl_r, ctrl_nx_s;
    logic [1:0]           num_levels_r, level_r, level_nx_s;
    logic [FS_WIDTH-1:0]  fs_r;
    logic [AW-1:0]        sig_len_r, cur_len_r, prev_len_r;
    logic [AW-1:0]        in_len_s, drain_cnt_r, drain_inc_s;
    logic [AW-1:0]        fs_ext_s, fs_in_ext_s, cnt_val_s;
    logic                 drain_en_s, drain_hit_s;
    logic                 cnt_load_s, cnt_dec_s, cnt_zero_s;

    assign fs_ext_s    = {{PAD{1'b0}}, fs_r};
    assign fs_in_ext_s = {{PAD{1'b0}}, filter_size};
    assign in_len_s    = (level_r == 2'd0) ? sig_len_r : cur_len_r;

    // Strobes count from the cycle after SETUP and saturate at the level's output length.
    assign drain_en_s  = fir_lp_output_valid && (drain_cnt_r != cur_len_r) &&
                         ((state_r == FEED) || (state_r == FLUSH) || (state_r == DRAIN));
    assign drain_inc_s = drain_cnt_r + {{(AW-1){1'b0}}, drain_en_s};
    assign drain_hit_s = (drain_inc_s == cur_len_r);

    wavelet_pe_phase_counter #(.WIDTH(AW)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // Next-state, phase-counter control and level advance.
    always_comb begin
        state_nx_s = state_r;
        level_nx_s = level_r;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        cnt_val_s  = '0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    level_nx_s = 2'd0;
                    if (signal_len == '0) begin
                        state_nx_s = ERR;
                    end else begin
                        state_nx_s = INIT;
                        cnt_load_s = 1'b1;
                        cnt_val_s  = fs_in_ext_s;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            INIT: begin
                if (cnt_zero_s) begin
                    state_nx_s = SETUP;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            SETUP: begin
                // A zero-length level (possible deep in the pyramid) skips straight past FEED.
                if (in_len_s != '0) begin
                    state_nx_s = FEED;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = in_len_s - AW'(1);
                end else if (fs_r != '0) begin
                    state_nx_s = FLUSH;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = fs_ext_s - AW'(1);
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            FEED: begin
                if (!cnt_zero_s) begin
                    cnt_dec_s = 1'b1;
                end else if (fs_r != '0) begin
                    state_nx_s = FLUSH;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = fs_ext_s - AW'(1);
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            FLUSH: begin
                if (cnt_zero_s) begin
                    state_nx_s = DRAIN;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            DRAIN: begin
                if (!drain_hit_s) begin
                    state_nx_s = DRAIN;
                end else if (level_r == num_levels_r) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SETUP;
                    level_nx_s = level_r + 2'd1;
                end
            end
            DONE:    state_nx_s = IDLE;
            ERR:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Control outputs for the state being entered, so the registers line up with state_r.
    always_comb begin
        ctrl_nx_s = '0;
        ctrl_nx_s.pe_init            = (state_r == IDLE) && (state_nx_s == INIT);
        ctrl_nx_s.obuff_hp_force_cen = (state_r == DRAIN) && (state_nx_s == SETUP);
        ctrl_nx_s.busy               = (state_nx_s != IDLE) && (state_nx_s != ERR);
        case (state_nx_s)
            IDLE: begin
                ctrl_nx_s.fir_force_freeze = 1'b1;
            end
            INIT: begin
                ctrl_nx_s.init_in_progress = 1'b1;
                ctrl_nx_s.fir_init         = 1'b1;
                ctrl_nx_s.fir_force_freeze = 1'b1;
            end
            SETUP: begin
                ctrl_nx_s.ibuff_base_rst    = 1'b1;
                ctrl_nx_s.ibuff_offset_rst  = 1'b1;
                ctrl_nx_s.obuff_offset_rst  = 1'b1;
                ctrl_nx_s.obuff_hp_base_rst = (level_nx_s == 2'd0);
                ctrl_nx_s.obuff_lp_base_rst = (level_nx_s == 2'd0);
            end
            FEED: begin
                ctrl_nx_s.fir_hp_valid         = 1'b1;
                ctrl_nx_s.fir_lp_valid         = 1'b1;
                ctrl_nx_s.ibuff_offset_cen     = 1'b1;
                ctrl_nx_s.ibuff_offset_upcount = 1'b1;
            end
            FLUSH: begin
                ctrl_nx_s.fir_flush            = 1'b1;
                ctrl_nx_s.fir_disable_freezing = 1'b1;
            end
            DONE: begin
                ctrl_nx_s.done             = 1'b1;
                ctrl_nx_s.fir_force_freeze = 1'b1;
            end
            ERR: begin
                ctrl_nx_s.done = 1'b1;
                ctrl_nx_s.err  = 1'b1;
            end
            default: begin
                ctrl_nx_s.fir_force_freeze = 1'b0;
            end
        endcase
    end

    // State, level, latched run parameters and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            ctrl_r       <= '0;
            level_r      <= 2'd0;
            num_levels_r <= 2'd0;
            fs_r         <= '0;
            sig_len_r    <= '0;
        end else begin
            state_r <= state_nx_s;
            ctrl_r  <= ctrl_nx_s;
            level_r <= level_nx_s;
            if ((state_r == IDLE) && start) begin
                num_levels_r <= num_levels;
                fs_r         <= filter_size;
                sig_len_r    <= signal_len;
            end
        end
    end

    // Per-level input/output lengths are fixed during SETUP.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_len_r  <= '0;
            prev_len_r <= '0;
        end else if (state_r == SETUP) begin
            prev_len_r <= in_len_s;
            cur_len_r  <= out_len(in_len_s, fs_r);
        end
    end

    // LP strobe counter, restarted at every SETUP.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt_r <= '0;
        end else if (state_r == SETUP) begin
            drain_cnt_r <= '0;
        end else begin
            drain_cnt_r <= drain_inc_s;
        end
    end

    assign pe_init                     = ctrl_r.pe_init;
    assign init_in_progress            = ctrl_r.init_in_progress;
    assign fir_init                    = ctrl_r.fir_init;
    assign cur_dec_level               = level_r;
    assign cur_outputs_len             = cur_len_r;
    assign prev_outputs_len            = prev_len_r;
    assign ibuff_r_addr_base_reg_rst   = ctrl_r.ibuff_base_rst;
    assign ibuff_r_addr_offset_rst     = ctrl_r.ibuff_offset_rst;
    assign ibuff_r_addr_offset_cen     = ctrl_r.ibuff_offset_cen;
    assign ibuff_r_addr_offset_upcount = ctrl_r.ibuff_offset_upcount;
    assign fir_hp_input_valid          = ctrl_r.fir_hp_valid;
    assign fir_lp_input_valid          = ctrl_r.fir_lp_valid;
    assign fir_flush_pipeline          = ctrl_r.fir_flush;
    assign fir_disable_freezing        = ctrl_r.fir_disable_freezing;
    assign fir_force_freeze            = ctrl_r.fir_force_freeze;
    assign obuff_w_offset_rst          = ctrl_r.obuff_offset_rst;
    assign obuff_w_hp_base_reg_rst     = ctrl_r.obuff_hp_base_rst;
    assign obuff_w_lp_base_reg_rst     = ctrl_r.obuff_lp_base_rst;
    assign obuff_w_hp_force_cen        = ctrl_r.obuff_hp_force_cen;
    assign busy                        = ctrl_r.busy;
    assign done                        = ctrl_r.done;
    assign err                         = ctrl_r.err;
endmodule

// File: tb/tb_wavelet_pe_controller.sv
// Randomized bench for wavelet_pe_controller: runs are observed cycle by cycle and
// compared with phase lengths and output counts derived from the level-length arithmetic.
module tb_wavelet_pe_controller;
    import wavelet_pe_pkg::*;
    localparam int AW = OBUFF_ADDR_WIDTH;
    localparam int C_IDLE = 0, C_INIT = 1, C_SETUP = 2, C_FEED = 3;
    localparam int C_FLUSH = 4, C_DRAIN = 5, C_DONE = 6, C_ERR = 7;

    logic clk = 1'b0;
    logic rst, start, fir_lp_output_valid;
    logic [1:0] num_levels;
    logic [AW-1:0] signal_len;
    logic [FS_WIDTH-1:0] filter_size;
    logic pe_init, init_in_progress, fir_init;
    logic [1:0] cur_dec_level;
    logic [AW-1:0] cur_outputs_len, prev_outputs_len;
    logic ibuff_r_addr_base_reg_rst, ibuff_r_addr_offset_rst, ibuff_r_addr_offset_cen, ibuff_r_addr_offset_upcount;
    logic fir_hp_input_valid, fir_lp_input_valid, fir_flush_pipeline, fir_disable_freezing, fir_force_freeze;
    logic obuff_w_offset_rst, obuff_w_hp_base_reg_rst, obuff_w_lp_base_reg_rst, obuff_w_hp_force_cen;
    logic busy, done, err;
    logic [42:0] all_outs;

    int total = 0, bad = 0;
    int pe_init_cnt, pe_init_first, init_cyc, hp_force_cnt, done_cnt, err_cnt, exit_bad;
    int incoh, freeze_bad, counted_total, first_cls, busy_first, busy_after, timeout;
    int base_rst_l0, base_rst_hi, post_abort_done;
    logic [42:0] rst_snap;
    int feed_obs[4], flush_obs[4], cur_obs[4], prev_obs[4], lvl_obs[4];
    int exp_in[5], exp_out[4];

    always #5 clk = ~clk;

    wavelet_pe_controller dut (
        .clk(clk), .rst(rst), .start(start), .num_levels(num_levels), .signal_len(signal_len),
        .filter_size(filter_size), .fir_lp_output_valid(fir_lp_output_valid),
        .pe_init(pe_init), .init_in_progress(init_in_progress), .fir_init(fir_init),
        .cur_dec_level(cur_dec_level), .cur_outputs_len(cur_outputs_len), .prev_outputs_len(prev_outputs_len),
        .ibuff_r_addr_base_reg_rst(ibuff_r_addr_base_reg_rst), .ibuff_r_addr_offset_rst(ibuff_r_addr_offset_rst),
        .ibuff_r_addr_offset_cen(ibuff_r_addr_offset_cen), .ibuff_r_addr_offset_upcount(ibuff_r_addr_offset_upcount),
        .fir_hp_input_valid(fir_hp_input_valid), .fir_lp_input_valid(fir_lp_input_valid),
        .fir_flush_pipeline(fir_flush_pipeline), .fir_disable_freezing(fir_disable_freezing),
        .fir_force_freeze(fir_force_freeze), .obuff_w_offset_rst(obuff_w_offset_rst),
        .obuff_w_hp_base_reg_rst(obuff_w_hp_base_reg_rst), .obuff_w_lp_base_reg_rst(obuff_w_lp_base_reg_rst),
        .obuff_w_hp_force_cen(obuff_w_hp_force_cen), .busy(busy), .done(done), .err(err)
    );

    assign all_outs = {pe_init, init_in_progress, fir_init, cur_dec_level, cur_outputs_len, prev_outputs_len,
                       ibuff_r_addr_base_reg_rst, ibuff_r_addr_offset_rst, ibuff_r_addr_offset_cen,
                       ibuff_r_addr_offset_upcount, fir_hp_input_valid, fir_lp_input_valid, fir_flush_pipeline,
                       fir_disable_freezing, fir_force_freeze, obuff_w_offset_rst, obuff_w_hp_base_reg_rst,
                       obuff_w_lp_base_reg_rst, obuff_w_hp_force_cen, busy, done, err};

    // Phase of the current cycle, inferred only from which controls are asserted.
    function automatic int classify();
        if (err) return C_ERR;
        if (done) return C_DONE;
        if (init_in_progress) return C_INIT;
        if (ibuff_r_addr_base_reg_rst) return C_SETUP;
        if (fir_hp_input_valid) return C_FEED;
        if (fir_flush_pipeline) return C_FLUSH;
        if (busy) return C_DRAIN;
        return C_IDLE;
    endfunction

    // Drives one run and records what was observed; tests compare the records.
    task automatic run_seq(input int sig, input int fs, input int nl, input int pct,
                           input bit poke, input int abort_at);
        int lvl, mcnt, cyc, c, expect_next;
        bit prev_setup, fin, s, exp_freeze;
        exp_in[0] = sig;
        for (int l = 0; l < 4; l++) begin
            exp_out[l] = (exp_in[l] + fs) / 2;
            if (exp_out[l] > OBUFF_CELL_COUNT - 1) exp_out[l] = OBUFF_CELL_COUNT - 1;
            exp_in[l+1] = exp_out[l];
            feed_obs[l] = 0; flush_obs[l] = 0; cur_obs[l] = -1; prev_obs[l] = -1; lvl_obs[l] = -1;
        end
        pe_init_cnt = 0; pe_init_first = 0; init_cyc = 0; hp_force_cnt = 0; done_cnt = 0; err_cnt = 0;
        exit_bad = 0; incoh = 0; freeze_bad = 0; counted_total = 0; first_cls = -1; busy_first = 0;
        base_rst_l0 = 0; base_rst_hi = 0; post_abort_done = 0; rst_snap = '1;
        @(negedge clk);
        signal_len = AW'(sig); filter_size = FS_WIDTH'(fs); num_levels = 2'(nl);
        start = 1'b1; fir_lp_output_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lvl = -1; mcnt = 0; expect_next = -1; prev_setup = 1'b0; fin = 1'b0; timeout = 1;
        for (cyc = 0; cyc < 20000 && !fin; cyc++) begin
            c = classify();
            if (expect_next >= 0 && c != expect_next) exit_bad++;
            expect_next = -1;
            if (cyc == 0) begin
                first_cls = c; busy_first = int'(busy); pe_init_first = int'(pe_init);
            end
            if (pe_init) pe_init_cnt++;
            if (init_in_progress && fir_init) init_cyc++;
            if (obuff_w_hp_force_cen) hp_force_cnt++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if ((fir_lp_input_valid != fir_hp_input_valid) || (ibuff_r_addr_offset_cen != fir_hp_input_valid) ||
                (ibuff_r_addr_offset_upcount != fir_hp_input_valid) || (fir_disable_freezing != fir_flush_pipeline) ||
                (ibuff_r_addr_offset_rst != ibuff_r_addr_base_reg_rst) || (obuff_w_offset_rst != ibuff_r_addr_base_reg_rst) ||
                (fir_init != init_in_progress) || (obuff_w_lp_base_reg_rst != obuff_w_hp_base_reg_rst))
                incoh++;
            exp_freeze = (c == C_INIT) || (c == C_DONE);
            if (c != C_IDLE && fir_force_freeze !== exp_freeze) freeze_bad++;
            if (prev_setup && lvl >= 0) begin
                cur_obs[lvl] = int'(cur_outputs_len); prev_obs[lvl] = int'(prev_outputs_len);
                lvl_obs[lvl] = int'(cur_dec_level);
            end
            prev_setup = (c == C_SETUP);
            if (c == C_SETUP) begin
                lvl++; mcnt = 0;
                if (lvl > 3) lvl = 3;
                if (lvl == 0) begin
                    if (obuff_w_hp_base_reg_rst) base_rst_l0++;
                end else begin
                    if (obuff_w_hp_base_reg_rst) base_rst_hi++;
                end
            end
            if (c == C_FEED && lvl >= 0) feed_obs[lvl]++;
            if (c == C_FLUSH && lvl >= 0) flush_obs[lvl]++;
            s = ($urandom_range(0, 99) < pct);
            fir_lp_output_valid = s;
            if ((c == C_FEED || c == C_FLUSH || c == C_DRAIN) && lvl >= 0 && s && mcnt < exp_out[lvl]) begin
                mcnt++; counted_total++;
            end
            if (c == C_DRAIN && lvl >= 0)
                expect_next = (mcnt == exp_out[lvl]) ? ((lvl == nl) ? C_DONE : C_SETUP) : C_DRAIN;
            if (poke && c == C_FEED && lvl == 0 && feed_obs[0] == 2) begin
                start = 1'b1;
                signal_len = AW'($urandom_range(1, 2047));
                filter_size = FS_WIDTH'($urandom_range(0, 15));
                num_levels = 2'($urandom_range(0, 3));
            end else begin
                start = 1'b0;
            end
            if (c == C_DONE || c == C_ERR) begin fin = 1'b1; timeout = 0; end
            if (abort_at > 0 && c == C_FEED && lvl == 0 && feed_obs[0] == abort_at) begin
                rst = 1'b1; fin = 1'b1; timeout = 0;
            end
            @(negedge clk);
        end
        fir_lp_output_valid = 1'b0; start = 1'b0;
        busy_after = int'(busy);
        if (rst) begin
            rst_snap = all_outs;
            rst = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done) post_abort_done++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; signal_len = AW'(8); filter_size = FS_WIDTH'(3);
        num_levels = 2'd0; fir_lp_output_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (all_outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_outs); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (fir_force_freeze !== 1'b1) begin bad++; $display("FAIL idle_freeze got=%b want=1", fir_force_freeze); end
    endtask

    task automatic test_single_level();
        run_seq(8, 3, 0, 60, 1'b0, 0);
        total++; if (timeout !== 0) begin bad++; $display("FAIL single_timeout got=%0d want=0", timeout); end
        total++; if (pe_init_first !== 1 || pe_init_cnt !== 1) begin bad++; $display("FAIL single_pe_init first=%0d cnt=%0d want=1/1", pe_init_first, pe_init_cnt); end
        total++; if (init_cyc !== 4) begin bad++; $display("FAIL single_init got=%0d want=4", init_cyc); end
        total++; if (feed_obs[0] !== 8) begin bad++; $display("FAIL single_feed got=%0d want=8", feed_obs[0]); end
        total++; if (flush_obs[0] !== 3) begin bad++; $display("FAIL single_flush got=%0d want=3", flush_obs[0]); end
        total++; if (cur_obs[0] !== 5 || prev_obs[0] !== 8) begin bad++; $display("FAIL single_len cur=%0d prev=%0d want=5/8", cur_obs[0], prev_obs[0]); end
        total++; if (exit_bad !== 0) begin bad++; $display("FAIL single_exit_timing got=%0d want=0", exit_bad); end
        total++; if (done_cnt !== 1 || err_cnt !== 0) begin bad++; $display("FAIL single_done done=%0d err=%0d want=1/0", done_cnt, err_cnt); end
        total++; if (counted_total !== 5) begin bad++; $display("FAIL single_strobes got=%0d want=5", counted_total); end
        total++; if (incoh !== 0 || freeze_bad !== 0) begin bad++; $display("FAIL single_ctrl incoh=%0d freeze=%0d want=0/0", incoh, freeze_bad); end
        total++; if (base_rst_l0 !== 1 || hp_force_cnt !== 0) begin bad++; $display("FAIL single_base base=%0d force=%0d want=1/0", base_rst_l0, hp_force_cnt); end
        total++; if (busy_first !== 1 || busy_after !== 0) begin bad++; $display("FAIL single_busy first=%0d after=%0d want=1/0", busy_first, busy_after); end
    endtask

    task automatic test_two_levels();
        run_seq(8, 3, 1, 50, 1'b0, 0);
        total++; if (feed_obs[1] !== 5) begin bad++; $display("FAIL two_feed1 got=%0d want=5", feed_obs[1]); end
        total++; if (prev_obs[1] !== 5 || cur_obs[1] !== 4) begin bad++; $display("FAIL two_len1 prev=%0d cur=%0d want=5/4", prev_obs[1], cur_obs[1]); end
        total++; if (hp_force_cnt !== 1) begin bad++; $display("FAIL two_force got=%0d want=1", hp_force_cnt); end
        total++; if (counted_total !== 9 || done_cnt !== 1) begin bad++; $display("FAIL two_done strobes=%0d done=%0d want=9/1", counted_total, done_cnt); end
        total++; if (lvl_obs[0] !== 0 || lvl_obs[1] !== 1) begin bad++; $display("FAIL two_level l0=%0d l1=%0d want=0/1", lvl_obs[0], lvl_obs[1]); end
        total++; if (exit_bad !== 0 || base_rst_hi !== 0) begin bad++; $display("FAIL two_exit exit=%0d base_hi=%0d want=0/0", exit_bad, base_rst_hi); end
    endtask

    task automatic test_err();
        run_seq(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 50, 1'b0, 0);
        total++; if (first_cls !== C_ERR) begin bad++; $display("FAIL err_first got=%0d want=%0d", first_cls, C_ERR); end
        total++; if (done_cnt !== 1 || err_cnt !== 1) begin bad++; $display("FAIL err_pulse done=%0d err=%0d want=1/1", done_cnt, err_cnt); end
        total++; if (init_cyc !== 0 || pe_init_cnt !== 0) begin bad++; $display("FAIL err_no_init init=%0d pe=%0d want=0/0", init_cyc, pe_init_cnt); end
        total++; if (busy_first !== 0 || busy_after !== 0) begin bad++; $display("FAIL err_busy first=%0d after=%0d want=0/0", busy_first, busy_after); end
    endtask

    task automatic test_start_in_feed();
        run_seq(8, 3, 1, 50, 1'b1, 0);
        total++; if (feed_obs[0] !== 8 || feed_obs[1] !== 5) begin bad++; $display("FAIL poke_feed f0=%0d f1=%0d want=8/5", feed_obs[0], feed_obs[1]); end
        total++; if (cur_obs[1] !== 4 || hp_force_cnt !== 1) begin bad++; $display("FAIL poke_len cur1=%0d force=%0d want=4/1", cur_obs[1], hp_force_cnt); end
        total++; if (done_cnt !== 1 || exit_bad !== 0 || pe_init_cnt !== 1) begin bad++; $display("FAIL poke_done done=%0d exit=%0d pe=%0d want=1/0/1", done_cnt, exit_bad, pe_init_cnt); end
    endtask

    task automatic test_abort();
        run_seq(8, 3, 0, 50, 1'b0, 3);
        total++; if (rst_snap !== '0) begin bad++; $display("FAIL abort_outputs got=%h want=0", rst_snap); end
        total++; if (done_cnt !== 0 || post_abort_done !== 0) begin bad++; $display("FAIL abort_done run=%0d after=%0d want=0/0", done_cnt, post_abort_done); end
        run_seq(8, 3, 0, 50, 1'b0, 0);
        total++; if (init_cyc !== 4 || feed_obs[0] !== 8 || cur_obs[0] !== 5) begin bad++; $display("FAIL abort_rerun init=%0d feed=%0d cur=%0d want=4/8/5", init_cyc, feed_obs[0], cur_obs[0]); end
        total++; if (done_cnt !== 1 || exit_bad !== 0) begin bad++; $display("FAIL abort_rerun_done done=%0d exit=%0d want=1/0", done_cnt, exit_bad); end
    endtask

    task automatic test_long_fs0();
        run_seq(2047, 0, 0, 50, 1'b0, 0);
        total++; if (flush_obs[0] !== 0 || feed_obs[0] !== 2047) begin bad++; $display("FAIL long_phases flush=%0d feed=%0d want=0/2047", flush_obs[0], feed_obs[0]); end
        total++; if (cur_obs[0] !== 1023) begin bad++; $display("FAIL long_len got=%0d want=1023", cur_obs[0]); end
        total++; if (counted_total !== 1023 || done_cnt !== 1 || exit_bad !== 0) begin bad++; $display("FAIL long_done strobes=%0d done=%0d exit=%0d want=1023/1/0", counted_total, done_cnt, exit_bad); end
    endtask

    task automatic test_random();
        int sig, fs, nl, sum;
        for (int r = 0; r < 8; r++) begin
            sig = int'($urandom_range(1, 200));
            fs  = int'($urandom_range(0, 15));
            nl  = int'($urandom_range(0, 3));
            run_seq(sig, fs, nl, int'($urandom_range(30, 90)), 1'b0, 0);
            sum = 0;
            total++; if (init_cyc !== fs + 1) begin bad++; $display("FAIL rnd_init run=%0d got=%0d want=%0d", r, init_cyc, fs + 1); end
            for (int l = 0; l <= nl; l++) begin
                sum += exp_out[l];
                total++;
                if (feed_obs[l] !== exp_in[l] || flush_obs[l] !== fs || cur_obs[l] !== exp_out[l] ||
                    prev_obs[l] !== exp_in[l] || lvl_obs[l] !== l) begin
                    bad++;
                    $display("FAIL rnd_level run=%0d lvl=%0d feed=%0d/%0d flush=%0d/%0d cur=%0d/%0d prev=%0d/%0d lv=%0d",
                             r, l, feed_obs[l], exp_in[l], flush_obs[l], fs, cur_obs[l], exp_out[l], prev_obs[l], exp_in[l], lvl_obs[l]);
                end
            end
            total++; if (hp_force_cnt !== nl) begin bad++; $display("FAIL rnd_force run=%0d got=%0d want=%0d", r, hp_force_cnt, nl); end
            total++; if (counted_total !== sum || done_cnt !== 1 || timeout !== 0) begin bad++; $display("FAIL rnd_done run=%0d strobes=%0d/%0d done=%0d timeout=%0d", r, counted_total, sum, done_cnt, timeout); end
            total++; if (exit_bad !== 0 || incoh !== 0 || freeze_bad !== 0) begin bad++; $display("FAIL rnd_ctrl run=%0d exit=%0d incoh=%0d freeze=%0d want=0", r, exit_bad, incoh, freeze_bad); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; fir_lp_output_valid = 1'b0;
        num_levels = 2'd0; signal_len = '0; filter_size = '0;
        test_reset();
        test_single_level();
        test_two_levels();
        test_err();
        test_start_in_feed();
        test_abort();
        test_long_fs0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
